// File: rtl/lc3b_types.sv
// ----------------------------------------------------------------------------
// lc3b_types
//   Shared types for the LC-3b pipeline controller.
//   - pipe_i_state_t : i-cache side handshake states (fetch / hold)
//   - pipe_d_state_t : d-cache side handshake states (idle / done)
//   - mem_fsm_state_t: generic request/hold state used by pipe_mem_fsm
//   - pipe_loads_t   : bundle of pipeline-register load enables
//   - pipe_valid_t   : bundle of per-stage valid bits
// ----------------------------------------------------------------------------
package lc3b_types;

  typedef enum logic {
    I_FETCH = 1'b0,
    I_HOLD  = 1'b1
  } pipe_i_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_DONE = 1'b1
  } pipe_d_state_t;

  // Generic form of the two handshakes: a request is outstanding, or the
  // response has been captured and the side is waiting for the other one.
  typedef enum logic {
    MS_REQ  = 1'b0,
    MS_HELD = 1'b1
  } mem_fsm_state_t;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } pipe_loads_t;

  typedef struct packed {
    logic id;
    logic ex;
    logic mem;
    logic wb;
  } pipe_valid_t;

endpackage

// File: rtl/pipe_mem_fsm.sv
// ----------------------------------------------------------------------------
// pipe_mem_fsm
//   Two-state request/hold handshake for one cache side. While in MS_REQ the
//   strobe is driven whenever the side needs memory. A response that arrives
//   while the pipeline cannot advance is remembered in MS_HELD, where no
//   strobe is driven so the access is never re-issued; the pipeline advance
//   returns the FSM to MS_REQ.
//
// Ports:
//   clk   in  pipeline clock
//   reset in  synchronous active-high reset (returns to MS_REQ)
//   need  in  this side has an access to perform this cycle
//   resp  in  cache response for this side
//   adv   in  pipeline advances at the coming edge
//   req   out strobe enable (0 during reset)
//   held  out response already captured, waiting for the other side
// ----------------------------------------------------------------------------
module pipe_mem_fsm
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic need,
  input  logic resp,
  input  logic adv,
  output logic req,
  output logic held
);

  mem_fsm_state_t state, state_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= MS_REQ;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this combinational process from
  // inferring a latch on paths that leave the state unchanged.
  always_comb begin
    state_next = state;
    case (state)
      MS_REQ:  if (need && resp && !adv) state_next = MS_HELD;
      MS_HELD: if (adv)                  state_next = MS_REQ;
      default:                           state_next = MS_REQ;
    endcase
  end

  always_comb begin
    req  = 1'b0;
    held = 1'b0;
    if (!reset) begin
      req  = (state == MS_REQ) && need;
      held = (state == MS_HELD);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//   Stall / bubble / flush controller for the five-stage LC-3b pipeline.
//   Drives every pipeline-register load and the PC load, tracks a valid bit
//   per stage, and sequences the i-cache and d-cache handshakes so the
//   pipeline advances only when both memory sides are satisfied.
//
//   Optional feature: define PIPE_PERF_EN to build the saturating stall,
//   bubble and flush counters; otherwise the counter outputs are tied to 0.
//
// Parameters:
//   CNT_WIDTH     width of the performance counters
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_resp, d_resp                  cache responses
//   mem_is_read, mem_is_write       EX/MEM instruction is a load / store
//   load_use                        load-use hazard detected in ID
//   br_taken                        EX/MEM instruction redirects control
//   i_read, d_read, d_write         cache strobes
//   load_pc .. load_mem_wb          PC and pipeline-register load enables
//   pc_sel_target                   next PC is the branch target
//   valid_id .. valid_wb            per-stage valid bits
//   stall_cnt, bubble_cnt, flush_cnt performance counters
//   All outputs are 0 while reset is high.
// ----------------------------------------------------------------------------
module pipe_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_resp,
  input  logic                 d_resp,
  input  logic                 mem_is_read,
  input  logic                 mem_is_write,
  input  logic                 load_use,
  input  logic                 br_taken,
  output logic                 i_read,
  output logic                 d_read,
  output logic                 d_write,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 pc_sel_target,
  output logic                 valid_id,
  output logic                 valid_ex,
  output logic                 valid_mem,
  output logic                 valid_wb,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] bubble_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  pipe_valid_t   valid_q, valid_d;
  pipe_loads_t   loads;
  pipe_i_state_t i_state;
  pipe_d_state_t d_state;
  logic          pc_sel;
  logic          i_req, i_held;
  logic          d_req, d_held;
  logic          d_need;
  logic          i_ok, d_ok, adv;
  logic          flush, bubble;

  // An invalid MEM stage never touches the d-cache.
  assign d_need = valid_q.mem & (mem_is_read | mem_is_write);

  // The i-side always wants the next fetch word.
  pipe_mem_fsm u_i_fsm (
    .clk   (clk),
    .reset (reset),
    .need  (1'b1),
    .resp  (i_resp),
    .adv   (adv),
    .req   (i_req),
    .held  (i_held)
  );

  pipe_mem_fsm u_d_fsm (
    .clk   (clk),
    .reset (reset),
    .need  (d_need),
    .resp  (d_resp),
    .adv   (adv),
    .req   (d_req),
    .held  (d_held)
  );

  assign i_state = i_held ? I_HOLD : I_FETCH;
  assign d_state = d_held ? D_DONE : D_IDLE;

  // A side is satisfied by a response this cycle or one captured earlier.
  assign i_ok = i_resp | (i_state == I_HOLD);
  assign d_ok = ~d_need | d_resp | (d_state == D_DONE);
  assign adv  = i_ok & d_ok;

  assign flush  = adv & valid_q.mem & br_taken;
  assign bubble = adv & load_use & ~flush;

  // Load enables and next valid bits. A flush squashes IF/ID/EX (the fetched
  // word is discarded) but lets the redirecting instruction retire into WB.
  // A bubble freezes PC and IF/ID and injects an invalid slot into EX.
  always_comb begin
    loads   = '0;
    pc_sel  = 1'b0;
    valid_d = valid_q;
    if (flush) begin
      loads   = '1;
      pc_sel  = 1'b1;
      valid_d = '{id: 1'b0, ex: 1'b0, mem: 1'b0, wb: 1'b1};
    end else if (bubble) begin
      loads   = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
      valid_d = '{id: valid_q.id, ex: 1'b0, mem: valid_q.ex, wb: valid_q.mem};
    end else if (adv) begin
      loads   = '1;
      valid_d = '{id: 1'b1, ex: valid_q.id, mem: valid_q.ex, wb: valid_q.mem};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Outputs are forced low while reset is asserted so an abandoned access
  // drops its strobe immediately.
  always_comb begin
    i_read        = 1'b0;
    d_read        = 1'b0;
    d_write       = 1'b0;
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    pc_sel_target = 1'b0;
    valid_id      = 1'b0;
    valid_ex      = 1'b0;
    valid_mem     = 1'b0;
    valid_wb      = 1'b0;
    if (!reset) begin
      i_read        = i_req;
      d_read        = d_req & mem_is_read;
      d_write       = d_req & mem_is_write;
      load_pc       = loads.pc;
      load_if_id    = loads.if_id;
      load_id_ex    = loads.id_ex;
      load_ex_mem   = loads.ex_mem;
      load_mem_wb   = loads.mem_wb;
      pc_sel_target = pc_sel;
      valid_id      = valid_q.id;
      valid_ex      = valid_q.ex;
      valid_mem     = valid_q.mem;
      valid_wb      = valid_q.wb;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, bubble_q, flush_q;

  // Saturating counters: an all-ones value sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (!adv && !(&stall_q))   stall_q  <= stall_q  + CNT_WIDTH'(1);
      if (bubble && !(&bubble_q)) bubble_q <= bubble_q + CNT_WIDTH'(1);
      if (flush && !(&flush_q))  flush_q  <= flush_q  + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt  = reset ? '0 : stall_q;
  assign bubble_cnt = reset ? '0 : bubble_q;
  assign flush_cnt  = reset ? '0 : flush_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl. The driver applies one input vector per
//   cycle (just after the rising edge) and pushes the hand-computed expected
//   outputs into a scoreboard queue; the monitor pops and compares on the
//   falling edge. Counter expectations collapse to 0 when PIPE_PERF_EN is not
//   defined.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_resp = 1'b0, d_resp = 1'b0, mem_is_read = 1'b0, mem_is_write = 1'b0;
  logic load_use = 1'b0, br_taken = 1'b0;
  logic i_read, d_read, d_write;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic pc_sel_target;
  logic valid_id, valid_ex, valid_mem, valid_wb;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  pipe_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_resp        (i_resp),
    .d_resp        (d_resp),
    .mem_is_read   (mem_is_read),
    .mem_is_write  (mem_is_write),
    .load_use      (load_use),
    .br_taken      (br_taken),
    .i_read        (i_read),
    .d_read        (d_read),
    .d_write       (d_write),
    .load_pc       (load_pc),
    .load_if_id    (load_if_id),
    .load_id_ex    (load_id_ex),
    .load_ex_mem   (load_ex_mem),
    .load_mem_wb   (load_mem_wb),
    .pc_sel_target (pc_sel_target),
    .valid_id      (valid_id),
    .valid_ex      (valid_ex),
    .valid_mem     (valid_mem),
    .valid_wb      (valid_wb),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [12:0]   outs;   // {strobes[2:0], loads[4:0], pc_sel, valid[3:0]}
    bit            chk_cnt;
    logic [CW-1:0] s, b, f;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: compares whatever the DUT presents against the oldest entry.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t  e;
      logic [12:0] act;
      e   = sb.pop_front();
      act = {i_read, d_read, d_write,
             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             pc_sel_target, valid_id, valid_ex, valid_mem, valid_wb};
      check(act === e.outs, {e.name, " outs"}, act, e.outs);
      if (e.chk_cnt) begin
        check(stall_cnt  === e.s, {e.name, " stall_cnt"},  13'(stall_cnt),  13'(e.s));
        check(bubble_cnt === e.b, {e.name, " bubble_cnt"}, 13'(bubble_cnt), 13'(e.b));
        check(flush_cnt  === e.f, {e.name, " flush_cnt"},  13'(flush_cnt),  13'(e.f));
      end
    end
  end

  task automatic check(input bit ok, input string nm,
                       input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // One cycle of stimulus plus its expected response.
  task automatic cyc(input string nm, input bit rst, ir, dr, mr, mw, lu, br,
                     input logic [2:0] strb, input logic [4:0] lds,
                     input logic sel, input logic [3:0] vld,
                     input bit cc, input int es, input int eb, input int ef);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; i_resp = ir; d_resp = dr; mem_is_read = mr;
    mem_is_write = mw; load_use = lu; br_taken = br;
    e.name    = nm;
    e.outs    = {strb, lds, sel, vld};
    e.chk_cnt = cc;
    e.s       = PERF ? CW'(es) : '0;
    e.b       = PERF ? CW'(eb) : '0;
    e.f       = PERF ? CW'(ef) : '0;
    sb.push_back(e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    //    name      rst ir dr mr mw lu br  strb    loads     sel vld     cc  s  b  f
    cyc("rst0",     1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("rst1",     1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00000, 0, 4'b0000, 1, 0, 0, 0);
    // Reset release: valid bits fill id, id+ex, ...
    cyc("fill1",    0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b0000, 1, 0, 0, 0);
    cyc("fill2",    0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b1000, 0, 0, 0, 0);
    cyc("fill3",    0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b1100, 0, 0, 0, 0);
    cyc("fill4",    0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b1110, 0, 0, 0, 0);
    // I-cache miss for 3 cycles, then the response advances the same cycle.
    cyc("imiss1",   0, 0, 0, 0, 0, 0, 0, 3'b100, 5'b00000, 0, 4'b1111, 0, 0, 0, 0);
    cyc("imiss2",   0, 0, 0, 0, 0, 0, 0, 3'b100, 5'b00000, 0, 4'b1111, 0, 0, 0, 0);
    cyc("imiss3",   0, 0, 0, 0, 0, 0, 0, 3'b100, 5'b00000, 0, 4'b1111, 0, 0, 0, 0);
    cyc("ihit",     0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b1111, 1, 3, 0, 0);
    // Split responses, load in MEM: i first, d two cycles later.
    cyc("split0",   0, 1, 0, 1, 0, 0, 0, 3'b110, 5'b00000, 0, 4'b1111, 0, 0, 0, 0);
    cyc("split1",   0, 0, 0, 1, 0, 0, 0, 3'b010, 5'b00000, 0, 4'b1111, 0, 0, 0, 0);
    cyc("split2",   0, 0, 1, 1, 0, 0, 0, 3'b010, 5'b11111, 0, 4'b1111, 0, 0, 0, 0);
    // Split responses, store: d first (D_DONE drops the strobe), then i.
    cyc("dfirst0",  0, 0, 1, 0, 1, 0, 0, 3'b101, 5'b00000, 0, 4'b1111, 0, 0, 0, 0);
    cyc("dfirst1",  0, 1, 0, 0, 1, 0, 0, 3'b100, 5'b11111, 0, 4'b1111, 1, 6, 0, 0);
    // Load-use bubble.
    cyc("luse",     0, 1, 0, 0, 0, 1, 0, 3'b100, 5'b00111, 0, 4'b1111, 0, 0, 0, 0);
    cyc("luse_nx",  0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b1011, 1, 6, 1, 0);
    cyc("adv",      0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b1101, 0, 0, 0, 0);
    // Flush beats load-use.
    cyc("flush",    0, 1, 0, 0, 0, 1, 1, 3'b100, 5'b11111, 1, 4'b1110, 0, 0, 0, 0);
    // br_taken and mem_is_read ignored while MEM is invalid.
    cyc("fl_nx",    0, 1, 0, 1, 0, 0, 1, 3'b100, 5'b11111, 0, 4'b0001, 1, 6, 1, 1);
    cyc("post",     0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b1000, 0, 0, 0, 0);
    // Reset mid-access: everything drops at once, counters clear.
    cyc("rst_mid",  1, 1, 0, 0, 1, 0, 0, 3'b000, 5'b00000, 0, 4'b0000, 1, 0, 0, 0);
    cyc("rel_miss", 0, 0, 0, 0, 0, 0, 0, 3'b100, 5'b00000, 0, 4'b0000, 1, 0, 0, 0);
    cyc("rel_hit",  0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b0000, 1, 1, 0, 0);
    // Long stall: counter saturates at all-ones.
    for (int i = 0; i < 20; i++)
      cyc("sat",    0, 0, 0, 0, 0, 0, 0, 3'b100, 5'b00000, 0, 4'b1000, 0, 0, 0, 0);
    cyc("sat_chk",  0, 1, 0, 0, 0, 0, 0, 3'b100, 5'b11111, 0, 4'b1000, 1, 15, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
